// File: rtl/event_gen_pkg.sv
// Shared register map, timer control bit positions and helpers for the event generator.
package event_gen_pkg;

  typedef enum logic [2:0] {
    REG_IRQ_EN      = 3'd0,
    REG_EVT_EN      = 3'd1,
    REG_PENDING     = 3'd2,
    REG_PENDING_SET = 3'd3,
    REG_TMR_LOAD    = 3'd4,
    REG_TMR_CTRL    = 3'd5,
    REG_TMR_VALUE   = 3'd6
  } reg_off_e;

  localparam int TMR_CTRL_EN_BIT     = 0;
  localparam int TMR_CTRL_RELOAD_BIT = 1;
  localparam int TIMER_SRC_IDX       = 31;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [4:0] lowest_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/evt_wake_timer.sv
// Down-counting wake timer; expire is high during the cycle the running count sits at zero.
module evt_wake_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_wr,
  input  logic        en_wr,
  input  logic        reload_wr,
  input  logic [31:0] load_val,
  output logic [31:0] value,
  output logic        en,
  output logic        reload,
  output logic        expire
);

  assign expire = en & (value == 32'd0);

  // Control writes take precedence over counting; a zero load value never starts the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= 32'd0;
      en     <= 1'b0;
      reload <= 1'b0;
    end else begin
      if (ctrl_wr) reload <= reload_wr;
      if (ctrl_wr && !en_wr) begin
        en <= 1'b0;
      end else if (ctrl_wr && !en) begin
        if (load_val != 32'd0) begin
          en    <= 1'b1;
          value <= load_val;
        end
      end else if (en) begin
        if (value != 32'd0) begin
          value <= value - 32'd1;
        end else if (reload && (load_val != 32'd0)) begin
          value <= load_val;
        end else begin
          en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/event_gen_unit.sv
// Event/interrupt generator: APB register block, edge-detected pending sources and a wake timer.
module event_gen_unit
  import event_gen_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 31
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        events_i,
  input  logic                      irq_ack_i,
  input  logic [4:0]                irq_ack_id_i,
  output logic                      irq_o,
  output logic [4:0]                irq_id_o,
  output logic                      event_o
);

  localparam logic [31:0] SRC_MASK = ((32'd1 << NUM_SRC) - 32'd1) | (32'd1 << TIMER_SRC_IDX);

  logic               apb_wr, apb_rd;
  reg_off_e           off;
  logic [31:0]        irq_en, evt_en, pending, tmr_load;
  logic [NUM_SRC-1:0] evt_q;
  logic               event_r;
  logic [31:0]        hw_set, sw_set, set_bits, clr_bits, new_bits;
  logic [31:0]        tmr_value;
  logic               tmr_en, tmr_reload, tmr_expire;
  logic               unused_addr;

  assign apb_wr      = PSEL & PENABLE & PWRITE;
  assign apb_rd      = PSEL & PENABLE & ~PWRITE;
  assign off         = reg_off_e'(PADDR[4:2]);
  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign irq_o       = |(pending & irq_en);
  assign irq_id_o    = lowest_idx(pending & irq_en);
  assign event_o     = event_r;

  evt_wake_timer u_timer (
    .clk      (HCLK),
    .rst      (HRESET),
    .ctrl_wr  (apb_wr && (off == REG_TMR_CTRL)),
    .en_wr    (PWDATA[TMR_CTRL_EN_BIT]),
    .reload_wr(PWDATA[TMR_CTRL_RELOAD_BIT]),
    .load_val (tmr_load),
    .value    (tmr_value),
    .en       (tmr_en),
    .reload   (tmr_reload),
    .expire   (tmr_expire)
  );

  // Set/clear vectors for the pending update; sets are applied after clears so they win.
  always_comb begin
    hw_set                = 32'd0;
    hw_set[NUM_SRC-1:0]   = events_i & ~evt_q;
    hw_set[TIMER_SRC_IDX] = tmr_expire;
    sw_set   = (apb_wr && (off == REG_PENDING_SET)) ? PWDATA : 32'd0;
    set_bits = (hw_set | sw_set) & SRC_MASK;
    clr_bits = ((apb_wr && (off == REG_PENDING)) ? PWDATA : 32'd0) |
               (irq_ack_i ? (32'd1 << irq_ack_id_i) : 32'd0);
    new_bits = set_bits & ~pending;
  end

  // Register file, pending state and wake event; edge flops track the input level through reset.
  always_ff @(posedge HCLK) begin
    evt_q <= events_i;
    if (HRESET) begin
      irq_en   <= 32'd0;
      evt_en   <= 32'd0;
      tmr_load <= 32'd0;
      pending  <= 32'd0;
      event_r  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_bits) | set_bits;
      event_r <= |(new_bits & evt_en);
      if (apb_wr) begin
        case (off)
          REG_IRQ_EN:   irq_en   <= PWDATA;
          REG_EVT_EN:   evt_en   <= PWDATA;
          REG_TMR_LOAD: tmr_load <= PWDATA;
          default:      ;
        endcase
      end
    end
  end

  // Read mux, only driven during the access phase of a read.
  always_comb begin
    PRDATA = 32'd0;
    if (apb_rd) begin
      case (off)
        REG_IRQ_EN:    PRDATA = irq_en;
        REG_EVT_EN:    PRDATA = evt_en;
        REG_PENDING:   PRDATA = pending;
        REG_TMR_LOAD:  PRDATA = tmr_load;
        REG_TMR_CTRL:  PRDATA = {30'd0, tmr_reload, tmr_en};
        REG_TMR_VALUE: PRDATA = tmr_value;
        default:       PRDATA = 32'd0;
      endcase
    end else begin
      PRDATA = 32'd0;
    end
  end

endmodule

// File: tb/tb_event_gen_unit.sv
// Scoreboard bench for event_gen_unit: expectations are queued with stimulus and popped on sampling.
module tb_event_gen_unit;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [30:0] events_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        event_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v, obs;

  event_gen_unit #(.APB_ADDR_WIDTH(12), .NUM_SRC(31)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .events_i(events_i), .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .event_o(event_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, limit 200000");
    $fatal(1);
  end

  task automatic apb_write(input int off, input logic [31:0] d);
    @(negedge HCLK);
    PADDR = 12'(off * 4); PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int off, output logic [31:0] d);
    @(negedge HCLK);
    PADDR = 12'(off * 4); PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic ack(input logic [4:0] id);
    @(negedge HCLK);
    irq_ack_i = 1'b1; irq_ack_id_i = id;
    @(negedge HCLK);
    irq_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    exp_q.push_back(32'h0000_0080);
    obs = {23'd0, PSLVERR, PREADY, event_o, irq_o, irq_id_o, PRDATA == 32'd0};
    obs = obs >> 1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_status: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_pending: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_irq_ack();
    apb_write(0, 32'h8);
    @(negedge HCLK); events_i[3] = 1'b1;
    exp_q.push_back({26'd0, 1'b1, 5'd3});
    @(negedge HCLK);
    obs = {26'd0, irq_o, irq_id_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL irq_raise: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'h8);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL pending_edge: got %h want %h", obs, exp_v); end
    ack(5'd3);
    exp_q.push_back(32'd0);
    obs = {31'd0, irq_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL irq_after_ack: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL pending_after_ack: got %h want %h", obs, exp_v); end
    events_i[3] = 1'b0;
    apb_write(0, 32'd0);
  endtask

  task automatic test_event_pulse();
    int pulses;
    int irqs;
    apb_write(1, 32'h1);
    @(negedge HCLK); events_i[0] = 1'b1;
    exp_q.push_back(32'd1);
    @(negedge HCLK);
    obs = {31'd0, event_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL event_first: got %h want %h", obs, exp_v); end
    pulses = 0; irqs = int'(irq_o);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      pulses += int'(event_o); irqs += int'(irq_o);
    end
    exp_q.push_back(32'd0);
    obs = 32'(pulses);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL event_held_pulses: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    obs = 32'(irqs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL event_irq_quiet: got %h want %h", obs, exp_v); end
    events_i[0] = 1'b0;
    apb_write(2, 32'h1);
    apb_write(1, 32'd0);
  endtask

  task automatic test_set_priority();
    @(negedge HCLK); events_i[5] = 1'b1;
    @(negedge HCLK); events_i[5] = 1'b0;
    @(negedge HCLK);
    PADDR = 12'd8; PWDATA = 32'h20; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1; events_i[5] = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    events_i[5] = 1'b0;
    exp_q.push_back(32'h20);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL set_beats_w1c: got %h want %h", obs, exp_v); end
    apb_write(2, 32'h20);
    exp_q.push_back(32'd0);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL w1c_alone: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_pending_set();
    apb_write(1, 32'h40);
    apb_write(3, 32'h40);
    exp_q.push_back(32'd1);
    obs = {31'd0, event_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL swset_event: got %h want %h", obs, exp_v); end
    @(negedge HCLK);
    exp_q.push_back(32'd0);
    obs = {31'd0, event_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL swset_single_cycle: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'h40);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL swset_pending: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(3, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL swset_reads_zero: got %h want %h", obs, exp_v); end
    apb_write(3, 32'h40);
    exp_q.push_back(32'd0);
    obs = {31'd0, event_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL swset_already_pending: got %h want %h", obs, exp_v); end
    apb_write(2, 32'h40);
    apb_write(1, 32'd0);
  endtask

  task automatic test_irq_id();
    apb_write(3, 32'h84);
    apb_write(0, 32'h84);
    exp_q.push_back({26'd0, 1'b1, 5'd2});
    obs = {26'd0, irq_o, irq_id_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL irq_id_lowest: got %h want %h", obs, exp_v); end
    ack(5'd2);
    exp_q.push_back({26'd0, 1'b1, 5'd7});
    obs = {26'd0, irq_o, irq_id_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL irq_id_next: got %h want %h", obs, exp_v); end
    ack(5'd7);
    exp_q.push_back(32'd0);
    obs = {26'd0, irq_o, irq_id_o};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL irq_id_none: got %h want %h", obs, exp_v); end
    apb_write(0, 32'd0);
  endtask

  task automatic test_timer();
    logic [31:0] vals_r[9];
    logic [31:0] vals_o[6];
    vals_r = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    vals_o = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    apb_write(0, 32'h8000_0000);
    apb_write(4, 32'd3);
    apb_write(5, 32'h3);
    PADDR = 12'd24; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vals_r[i]);
      exp_q.push_back((i >= 4) ? 32'd1 : 32'd0);
      #1;
      obs = PRDATA;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL tmr_reload_value[%0d]: got %h want %h", i, obs, exp_v); end
      obs = {31'd0, irq_o};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL tmr_expiry_irq[%0d]: got %h want %h", i, obs, exp_v); end
      @(negedge HCLK);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_write(5, 32'd0);
    apb_write(2, 32'h8000_0000);
    apb_write(5, 32'h1);
    PADDR = 12'd24; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vals_o[i]);
      #1;
      obs = PRDATA;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL tmr_oneshot_value[%0d]: got %h want %h", i, obs, exp_v); end
      @(negedge HCLK);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_q.push_back(32'd0);
    apb_read(5, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL tmr_oneshot_ctrl: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'h8000_0000);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL tmr_oneshot_pending: got %h want %h", obs, exp_v); end
    apb_write(2, 32'h8000_0000);
    repeat (5) @(negedge HCLK);
    exp_q.push_back(32'd0);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL tmr_single_expiry: got %h want %h", obs, exp_v); end
    apb_write(4, 32'd0);
    apb_write(5, 32'h1);
    exp_q.push_back(32'd0);
    apb_read(5, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL tmr_zero_load_en: got %h want %h", obs, exp_v); end
    apb_write(0, 32'd0);
  endtask

  task automatic test_reset_abort();
    int evts;
    apb_write(4, 32'd10);
    apb_write(5, 32'h3);
    apb_write(0, 32'hFFFF_FFFF);
    apb_write(1, 32'hFFFF_FFFF);
    apb_write(3, 32'h2);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1; events_i = '1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    evts = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      evts += int'(event_o);
    end
    exp_q.push_back(32'd0);
    obs = {23'd0, PRDATA != 32'd0, event_o, irq_o, irq_id_o, 1'b0} | 32'(evts);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL abort_outputs: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(2, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL abort_pending: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(6, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL abort_tmr_value: got %h want %h", obs, exp_v); end
    exp_q.push_back(32'd0);
    apb_read(0, obs);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL abort_irq_en: got %h want %h", obs, exp_v); end
    events_i = '0;
  endtask

  initial begin
    HRESET = 1'b1; PADDR = 12'd0; PWDATA = 32'd0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    events_i = '0; irq_ack_i = 1'b0; irq_ack_id_i = 5'd0;
    test_reset();
    test_irq_ack();
    test_event_pulse();
    test_set_priority();
    test_pending_set();
    test_irq_id();
    test_timer();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
